// File: rtl/sys_bus_pkg.sv
// Shared definitions for the cache-side system bus bridge: FSM state
// encodings and the SysRW direction constants used by the cache controller.
package sys_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RDWAIT = 2'd1,
        ST_RDMEM  = 2'd2,
        ST_RESP   = 2'd3
    } bridge_state_e;

    localparam logic SYS_READ  = 1'b1;
    localparam logic SYS_WRITE = 1'b0;

endpackage

// File: rtl/write_buffer.sv
// One-entry posted write buffer: holds a single address/data pair until the
// memory side acknowledges its drain, and flags reads that hit the entry.
module write_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  load_on_ack_i,
    input  logic                  clear_on_ack_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ADDR_WIDTH-1:0] cmp_addr_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  hit_o
);

    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    // A reload on the ack edge wins over the clear, keeping the entry valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i || load_on_ack_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (clear_on_ack_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign hit_o   = valid_q && (addr_q == cmp_addr_i);

endmodule

// File: rtl/sys_bus_bridge.sv
// Bridge between the cache controller's strobe/ready interface and a req/ack
// memory port, with a posted write buffer and ordered, forwarding reads.
module sys_bus_bridge
    import sys_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  SysStrobe,
    input  logic                  SysRW,
    input  logic [ADDR_WIDTH-1:0] SysAddress,
    input  logic [DATA_WIDTH-1:0] SysWData,
    output logic [DATA_WIDTH-1:0] SysRData,
    output logic                  SysReady,
    output logic                  MemReq,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWData,
    input  logic [DATA_WIDTH-1:0] MemRData,
    input  logic                  MemAck,
    output logic                  WbPending
);

    bridge_state_e         state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] sys_rdata_q;
    logic                  sys_ready_q;
    logic                  mem_req_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic                  wb_valid;
    logic                  wb_hit;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    logic mem_ack, drain_ack, read_ack;
    logic is_wr, is_rd, wb_load, wb_reload, rd_issue_now;

    assign mem_ack   = mem_req_q && MemAck;
    assign drain_ack = mem_ack && mem_write_q;
    assign read_ack  = mem_ack && !mem_write_q;

    assign is_wr     = (state_q == ST_IDLE) && SysStrobe && (SysRW == SYS_WRITE);
    assign is_rd     = (state_q == ST_IDLE) && SysStrobe && (SysRW == SYS_READ);
    assign wb_load   = is_wr && !wb_valid;
    assign wb_reload = is_wr && wb_valid && drain_ack;
    // An empty buffer and idle port let a read miss go out on the next cycle.
    assign rd_issue_now = is_rd && !wb_valid && !mem_req_q;

    write_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wb (
        .clk_i          (clock),
        .rst_ni         (reset),
        .load_i         (wb_load),
        .load_on_ack_i  (wb_reload),
        .clear_on_ack_i (drain_ack),
        .addr_i         (SysAddress),
        .data_i         (SysWData),
        .cmp_addr_i     (SysAddress),
        .valid_o        (wb_valid),
        .addr_o         (wb_addr),
        .data_o         (wb_data),
        .hit_o          (wb_hit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            sys_rdata_q <= '0;
            sys_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            sys_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wb_load || wb_reload) begin
                        state_q     <= ST_RESP;
                        sys_ready_q <= 1'b1;
                    end else if (is_rd) begin
                        rd_addr_q <= SysAddress;
                        if (wb_hit) begin
                            sys_rdata_q <= wb_data;
                            state_q     <= ST_RESP;
                            sys_ready_q <= 1'b1;
                        end else if (wb_valid && !drain_ack) begin
                            state_q <= ST_RDWAIT;
                        end else begin
                            state_q <= ST_RDMEM;
                        end
                    end
                end
                ST_RDWAIT: begin
                    if (drain_ack || !wb_valid) begin
                        state_q <= ST_RDMEM;
                    end
                end
                ST_RDMEM: begin
                    if (read_ack) begin
                        sys_rdata_q <= MemRData;
                        state_q     <= ST_RESP;
                        sys_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Every acked transfer forces one idle cycle before the next one.
            if (mem_req_q) begin
                if (MemAck) begin
                    mem_req_q <= 1'b0;
                end
            end else if (rd_issue_now) begin
                mem_req_q   <= 1'b1;
                mem_write_q <= 1'b0;
                mem_addr_q  <= SysAddress;
            end else if (state_q == ST_RDMEM) begin
                mem_req_q   <= 1'b1;
                mem_write_q <= 1'b0;
                mem_addr_q  <= rd_addr_q;
            end else if (wb_valid) begin
                mem_req_q   <= 1'b1;
                mem_write_q <= 1'b1;
                mem_addr_q  <= wb_addr;
                mem_wdata_q <= wb_data;
            end
        end
    end

    assign SysRData   = sys_rdata_q;
    assign SysReady   = sys_ready_q;
    assign MemReq     = mem_req_q;
    assign MemWrite   = mem_write_q;
    assign MemAddress = mem_addr_q;
    assign MemWData   = mem_wdata_q;
    assign WbPending  = wb_valid;

endmodule

// File: doc/sys_bus_bridge.md
Name: sys_bus_bridge

Overview:
- Sits directly downstream of the cache controller: consumes its SysStrobe/SysRW requests and returns SysReady/read data.
- Drives the external memory port with a req/ack handshake.
- Holds a one-entry posted write buffer, so write-through stores complete to the cache in one cycle and drain to memory in the background.
- Reads keep ordering: they forward from the buffer on an address match, otherwise they wait for the drain to finish.

Parameters:
- ADDR_WIDTH, 32, width of SysAddress/MemAddress
- DATA_WIDTH, 32, width of all data buses

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- SysStrobe  in  1  request from cache controller; held high until SysReady
- SysRW  in  1  1=read, 0=write; valid with SysStrobe
- SysAddress  in  ADDR_WIDTH  request word address
- SysWData  in  DATA_WIDTH  write data from cache
- SysRData  out  DATA_WIDTH  read data to cache; registered
- SysReady  out  1  one-cycle completion pulse
- MemReq  out  1  memory request; registered, held until MemAck
- MemWrite  out  1  1=write access; stable while MemReq
- MemAddress  out  ADDR_WIDTH  memory address; stable while MemReq
- MemWData  out  DATA_WIDTH  memory write data; stable while MemReq
- MemRData  in  DATA_WIDTH  memory read data; valid when MemAck
- MemAck  in  1  memory completion; ignored while MemReq low
- WbPending  out  1  posted write buffer occupied (status)

Behaviour:
- Reset (reset=0, asynchronous) clears outputs and state immediately:
  - SysReady=0, SysRData=0, MemReq=0, MemWrite=0, MemAddress=0, MemWData=0, WbPending=0
  - State returns to IDLE.
  - A buffered write or outstanding read is discarded; no memory access completes after reset.
- Request FSM states: IDLE, RDWAIT (read waiting for drain), RDMEM (read MemReq outstanding), RESP (SysReady=1 for exactly one cycle, then IDLE).
- Requests are sampled only in IDLE. SysStrobe is ignored in RESP. The requester drops SysStrobe in the cycle after SysReady, otherwise it is taken as a new request.
- Write, buffer empty:
  - Capture {SysAddress, SysWData} into the buffer and set WbPending.
  - Go to RESP, so SysReady is high one cycle after acceptance.
- Write, buffer full: stay in IDLE (not accepted) until the drain MemAck edge. At that edge the new write loads the buffer (WbPending stays 1) and the FSM goes to RESP.
- Drain:
  - When WbPending=1 and the FSM is not in RDMEM, assert MemReq=1, MemWrite=1 with the buffer contents.
  - At the MemAck edge, clear WbPending (unless reloaded) and drop MemReq the next cycle.
- Read, buffer valid and address equal: forward the buffered data into SysRData and go to RESP (SysReady next cycle). No memory access. This applies even while that entry is draining.
- Read, buffer valid and address different: go to RDWAIT. At the drain MemAck edge go to RDMEM.
- Read, buffer empty: go to RDMEM.
- RDMEM:
  - MemReq=1, MemWrite=0, MemAddress=captured read address.
  - At the MemAck edge, register MemRData into SysRData, drop MemReq and go to RESP.
- MemReq is low for at least one cycle between consecutive memory transactions. It is never asserted for a drain and a read at once.
- Zero-wait memory (MemAck in the first MemReq cycle):
  - Read miss: strobe cycle 0, MemReq cycle 1, SysReady cycle 2.
  - Write or forwarded read: SysReady cycle 1.
- SysRData holds its value until the next read completes. Writes do not change it.
- Address compare is a full ADDR_WIDTH equality. There is no byte masking.

Decomposition:
- Package sys_bus_pkg:
  - FSM state encodings (IDLE, RDWAIT, RDMEM, RESP)
  - SYS_READ=1'b1 / SYS_WRITE=1'b0 constants shared with the cache controller
- Sub-module write_buffer:
  - one-entry address/data/valid register
  - load, clear-on-ack and load-on-ack-edge inputs
  - combinational hit compare output

Test Plan:
- Reset mid-operation: assert reset=0 while MemReq=1 during a drain -> MemReq, WbPending and SysReady go to 0 at once; after release, no MemAck-driven completion occurs.
- Write then read, same address: write 0x100=0xDEADBEEF with MemAck held off -> SysReady cycle 1, WbPending=1; read 0x100 -> SysReady next cycle, SysRData=0xDEADBEEF, no MemWrite=0 MemReq issued.
- Write then read, different address: write 0x100=0x11 then read 0x200, MemAck delayed 3 cycles per access -> drain completes first (MemWrite=1, 0x100), then MemReq read 0x200, then SysReady with memory data 0x22.
- Back-to-back writes: write 0x10=0xA, then write 0x14=0xB while the first is undrained -> second SysReady only after the first drain ack; memory sees 0xA then 0xB in order, MemReq low one cycle between them.
- Zero-wait read miss: buffer empty, MemAck=1 whenever MemReq, read 0x40 with MemRData=0x55 -> MemReq cycle 1 only, SysReady cycle 2 with SysRData=0x55, SysRData unchanged by a following write.
